// File: rtl/debug_ctrl_sequencer.sv
// Purpose: serialises one host debug command (start/stop/kill) over a core mask into per-core control messages; tracks per-core running/error state.
// Latency: accept at N, first message offered at N+2; start/kill cost 2 cycles per core, stop adds 1..TIMEOUT wait cycles per core.
// Backpressure: cmdReady only in IDLE (host holds cmdValid); message outputs held stable in SEND until msgReady.
module debug_ctrl_sequencer #(
  parameter int NCORES  = 16,
  parameter int SELF    = 1,
  parameter int TIMEOUT = 1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmdValid,
  input  logic [1:0]        cmdType,
  input  logic [NCORES-1:0] cmdMask,
  output logic              cmdReady,
  output logic              msgValid,
  output logic [3:0]        msgDest,
  output logic [3:0]        msgType,
  input  logic              msgReady,
  input  logic              statusValid,
  input  logic [3:0]        statusSrc,
  input  logic              statusRunning,
  output logic [NCORES-1:0] runMask,
  output logic [NCORES-1:0] errMask,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, SCAN, SEND, WAIT, DONE} state_t;

  localparam logic [1:0]        CMD_START    = 2'd0;
  localparam logic [1:0]        CMD_STOP     = 2'd1;
  localparam logic [1:0]        CMD_KILL     = 2'd2;
  localparam logic [1:0]        CMD_NOP      = 2'd3;
  localparam logic [15:0]       SELF_BIT     = (SELF < 16) ? (16'd1 << SELF) : 16'd0;
  localparam logic [NCORES-1:0] SELF_MASK    = SELF_BIT[NCORES-1:0];
  localparam logic [15:0]       TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t            state;
  state_t            stateNext;
  logic [1:0]        cmdTypeReg;
  logic [NCORES-1:0] pending;
  logic [3:0]        cur;
  logic [15:0]       waitCount;
  logic [3:0]        lowIdx;
  logic [15:0]       lowOneHot;
  logic [15:0]       curOneHot;
  logic [15:0]       srcOneHot;
  logic [NCORES-1:0] lowSel;
  logic [NCORES-1:0] curSel;
  logic [NCORES-1:0] srcSel;
  logic [NCORES-1:0] runMaskNext;
  logic              stopMatch;
  logic              timedOut;
  logic              sendAccept;

  // One-hot decodes; reports from indices beyond NCORES fall off the slice and are ignored
  assign lowOneHot  = 16'd1 << lowIdx;
  assign curOneHot  = 16'd1 << cur;
  assign srcOneHot  = 16'd1 << statusSrc;
  assign lowSel     = lowOneHot[NCORES-1:0];
  assign curSel     = curOneHot[NCORES-1:0];
  assign srcSel     = srcOneHot[NCORES-1:0];
  assign stopMatch  = statusValid && (statusSrc == cur) && !statusRunning;
  assign timedOut   = (waitCount == TIMEOUT_LAST);
  assign sendAccept = (state == SEND) && msgReady;
  assign msgDest    = cur;
  assign msgType    = {2'b00, cmdTypeReg};

  // Lowest-index pending core
  always_comb begin
    lowIdx = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (pending[i]) lowIdx = 4'(i);
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    stateNext = state;
    cmdReady  = 1'b0;
    msgValid  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmdReady = 1'b1;
        busy     = 1'b0;
        if (cmdValid) stateNext = SCAN;
      end
      SCAN: stateNext = (pending == '0) ? DONE : SEND;
      SEND: begin
        msgValid = 1'b1;
        if (msgReady) stateNext = (cmdTypeReg == CMD_STOP) ? WAIT : SCAN;
      end
      WAIT: if (stopMatch || timedOut) stateNext = SCAN;
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Running mask: status reports first, then the sequencer's own write overrides the same bit
  always_comb begin
    runMaskNext = runMask;
    if (statusValid) begin
      if (statusRunning) runMaskNext = runMaskNext | srcSel;
      else               runMaskNext = runMaskNext & ~srcSel;
    end
    if (sendAccept && cmdTypeReg == CMD_START) runMaskNext = runMaskNext | curSel;
    if (sendAccept && cmdTypeReg == CMD_KILL)  runMaskNext = runMaskNext & ~curSel;
    if (state == WAIT && stopMatch)            runMaskNext = runMaskNext & ~curSel;
  end

  // Command latch, core selection, stop timer and status masks
  always_ff @(posedge clock) begin
    if (reset) begin
      cmdTypeReg <= CMD_START;
      pending    <= '0;
      cur        <= '0;
      waitCount  <= '0;
      runMask    <= '0;
      errMask    <= '0;
    end else begin
      runMask <= runMaskNext;
      case (state)
        IDLE: if (cmdValid) begin
          cmdTypeReg <= cmdType;
          pending    <= (cmdType == CMD_NOP) ? '0 : (cmdMask & ~SELF_MASK);
          errMask    <= '0;
        end
        SCAN: if (pending != '0) begin
          cur     <= lowIdx;
          pending <= pending & ~lowSel;
        end
        SEND: if (msgReady && cmdTypeReg == CMD_STOP) waitCount <= '0;
        WAIT: if (!stopMatch) begin
          if (timedOut) errMask <= errMask | curSel;
          else          waitCount <= waitCount + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_ctrl_sequencer.sv
// Bench for debug_ctrl_sequencer: directed scenarios plus randomized start/kill/no-op commands against a mask-level model.
// Inputs are driven and outputs sampled at the falling edge; cycle c=1 is the first cycle after command acceptance.
// The DUT uses TIMEOUT=8 so stop timeouts are short.
module tb_debug_ctrl_sequencer;
  localparam int NC   = 16;
  localparam int SELF = 1;
  localparam int TMO  = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmdValid;
  logic [1:0]  cmdType;
  logic [15:0] cmdMask;
  logic        cmdReady;
  logic        msgValid;
  logic [3:0]  msgDest;
  logic [3:0]  msgType;
  logic        msgReady;
  logic        statusValid;
  logic [3:0]  statusSrc;
  logic        statusRunning;
  logic [15:0] runMask;
  logic [15:0] errMask;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  debug_ctrl_sequencer #(.NCORES(NC), .SELF(SELF), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .cmdValid(cmdValid), .cmdType(cmdType), .cmdMask(cmdMask),
    .cmdReady(cmdReady), .msgValid(msgValid), .msgDest(msgDest), .msgType(msgType), .msgReady(msgReady),
    .statusValid(statusValid), .statusSrc(statusSrc), .statusRunning(statusRunning),
    .runMask(runMask), .errMask(errMask), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; cmdValid = 1'b0; cmdType = 2'd0; cmdMask = 16'h0; msgReady = 1'b0;
    statusValid = 1'b0; statusSrc = 4'd0; statusRunning = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  // One idle cycle carrying a status report
  task automatic set_status(input logic [3:0] src, input logic run);
    statusValid = 1'b1; statusSrc = src; statusRunning = run;
    tick();
    statusValid = 1'b0;
  endtask

  // Present a command for one (idle) cycle; returns at the observation point of c=1
  task automatic issue(input logic [1:0] tp, input logic [15:0] mask);
    cmdValid = 1'b1; cmdType = tp; cmdMask = mask;
    tick();
    cmdValid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({cmdReady, msgValid, busy, done} !== 4'b1000) begin bad++; $display("FAIL reset_ctl got=%b exp=1000", {cmdReady, msgValid, busy, done}); end
    total++; if ({msgDest, msgType} !== 8'h00) begin bad++; $display("FAIL reset_msg got=%h exp=00", {msgDest, msgType}); end
    total++; if (runMask !== 16'h0) begin bad++; $display("FAIL reset_run got=%h exp=0000", runMask); end
    total++; if (errMask !== 16'h0) begin bad++; $display("FAIL reset_err got=%h exp=0000", errMask); end
  endtask

  task automatic test_start_basic();
    logic expV;
    logic [3:0] expD;
    msgReady = 1'b1;
    issue(2'd0, 16'h0007);
    for (int c = 1; c <= 7; c++) begin
      expV = (c == 2 || c == 4);
      expD = (c == 2) ? 4'd0 : 4'd2;
      total++; if (msgValid !== expV) begin bad++; $display("FAIL start_vld c=%0d got=%b exp=%b", c, msgValid, expV); end
      if (expV) begin
        total++; if ({msgDest, msgType} !== {expD, 4'd0}) begin bad++; $display("FAIL start_msg c=%0d got=%h exp=%h", c, {msgDest, msgType}, {expD, 4'd0}); end
      end
      total++; if (done !== (c == 6)) begin bad++; $display("FAIL start_done c=%0d got=%b", c, done); end
      if (c == 7) begin
        total++; if (cmdReady !== 1'b1) begin bad++; $display("FAIL start_rdy got=%b exp=1", cmdReady); end
        total++; if (runMask !== 16'h0005) begin bad++; $display("FAIL start_run got=%h exp=0005", runMask); end
      end else tick();
    end
  endtask

  task automatic test_stop_report();
    set_status(4'd0, 1'b0);
    total++; if (runMask !== 16'h0004) begin bad++; $display("FAIL stop_pre got=%h exp=0004", runMask); end
    msgReady = 1'b1;
    issue(2'd1, 16'h0004);
    for (int c = 1; c <= 10; c++) begin
      total++; if (msgValid !== (c == 2)) begin bad++; $display("FAIL stop_vld c=%0d got=%b", c, msgValid); end
      if (c == 2) begin
        total++; if ({msgDest, msgType} !== 8'h21) begin bad++; $display("FAIL stop_msg got=%h exp=21", {msgDest, msgType}); end
      end
      total++; if (done !== (c == 9)) begin bad++; $display("FAIL stop_done c=%0d got=%b", c, done); end
      total++; if (busy !== (c <= 9)) begin bad++; $display("FAIL stop_busy c=%0d got=%b", c, busy); end
      // WAIT2: core 2 still running; WAIT3: other core; WAIT5: the real confirmation
      statusValid = (c == 4 || c == 5 || c == 7);
      statusSrc   = (c == 5) ? 4'd6 : 4'd2;
      statusRunning = (c == 4);
      if (c < 10) tick();
    end
    statusValid = 1'b0;
    total++; if (runMask !== 16'h0000) begin bad++; $display("FAIL stop_run got=%h exp=0000", runMask); end
    total++; if (errMask !== 16'h0000) begin bad++; $display("FAIL stop_err got=%h exp=0000", errMask); end
  endtask

  task automatic test_timeout();
    logic expV;
    set_status(4'd3, 1'b1);
    set_status(4'd4, 1'b1);
    msgReady = 1'b1;
    issue(2'd1, 16'h0018);
    for (int c = 1; c <= 23; c++) begin
      expV = (c == 2 || c == 12);
      total++; if (msgValid !== expV) begin bad++; $display("FAIL tmo_vld c=%0d got=%b exp=%b", c, msgValid, expV); end
      if (expV) begin
        total++; if ({msgDest, msgType} !== {((c == 2) ? 4'd3 : 4'd4), 4'd1}) begin bad++; $display("FAIL tmo_msg c=%0d got=%h", c, {msgDest, msgType}); end
      end
      total++; if (done !== (c == 22)) begin bad++; $display("FAIL tmo_done c=%0d got=%b", c, done); end
      if (c == 10) begin total++; if (errMask !== 16'h0000) begin bad++; $display("FAIL tmo_err_early got=%h exp=0000", errMask); end end
      if (c == 11) begin total++; if (errMask !== 16'h0008) begin bad++; $display("FAIL tmo_err_set got=%h exp=0008", errMask); end end
      // Confirmation for core 4 lands on its last allowed wait cycle
      statusValid = (c == 20); statusSrc = 4'd4; statusRunning = 1'b0;
      if (c < 23) tick();
    end
    statusValid = 1'b0;
    total++; if (errMask !== 16'h0008) begin bad++; $display("FAIL tmo_err_end got=%h exp=0008", errMask); end
    total++; if (runMask !== 16'h0008) begin bad++; $display("FAIL tmo_run got=%h exp=0008", runMask); end
  endtask

  task automatic test_kill_stall();
    logic expV;
    set_status(4'd8, 1'b1);
    set_status(4'd9, 1'b1);
    msgReady = 1'b0;
    issue(2'd2, 16'h0300);
    // Host keeps a different command pending while the sequencer is busy
    cmdValid = 1'b1; cmdType = 2'd0; cmdMask = 16'hFFFF;
    for (int c = 1; c <= 12; c++) begin
      if (c == 1) begin total++; if (errMask !== 16'h0) begin bad++; $display("FAIL kill_errclr got=%h exp=0000", errMask); end end
      if (c <= 3) begin total++; if (cmdReady !== 1'b0) begin bad++; $display("FAIL kill_rdy c=%0d got=%b exp=0", c, cmdReady); end end
      expV = (c >= 2 && c <= 7) || c == 9;
      total++; if (msgValid !== expV) begin bad++; $display("FAIL kill_vld c=%0d got=%b exp=%b", c, msgValid, expV); end
      if (expV) begin
        total++; if ({msgDest, msgType} !== {((c == 9) ? 4'd9 : 4'd8), 4'd2}) begin bad++; $display("FAIL kill_msg c=%0d got=%h", c, {msgDest, msgType}); end
      end
      total++; if (done !== (c == 11)) begin bad++; $display("FAIL kill_done c=%0d got=%b", c, done); end
      if (c == 8) begin total++; if (runMask !== 16'h0208) begin bad++; $display("FAIL kill_run8 got=%h exp=0208", runMask); end end
      cmdValid = (c < 3);
      msgReady = (c >= 7);
      if (c < 12) tick();
    end
    total++; if (runMask !== 16'h0008) begin bad++; $display("FAIL kill_run got=%h exp=0008", runMask); end
    total++; if (cmdReady !== 1'b1) begin bad++; $display("FAIL kill_idle got=%b exp=1", cmdReady); end
  endtask

  task automatic test_fsm_wins();
    set_status(4'd5, 1'b1);
    total++; if (runMask !== 16'h0028) begin bad++; $display("FAIL unsol_set got=%h exp=0028", runMask); end
    msgReady = 1'b0;
    statusValid = 1'b1; statusSrc = 4'd5; statusRunning = 1'b0;
    issue(2'd2, 16'h0020);
    statusValid = 1'b0;
    total++; if (runMask !== 16'h0008) begin bad++; $display("FAIL unsol_acc got=%h exp=0008", runMask); end
    tick();
    total++; if ({msgValid, msgDest, msgType} !== 9'h152) begin bad++; $display("FAIL wins_msg got=%h exp=152", {msgValid, msgDest, msgType}); end
    statusValid = 1'b1; statusSrc = 4'd5; statusRunning = 1'b1; msgReady = 1'b1;
    tick();
    total++; if (runMask !== 16'h0008) begin bad++; $display("FAIL wins_run got=%h exp=0008", runMask); end
    tick();
    statusValid = 1'b0;
    total++; if (runMask !== 16'h0028) begin bad++; $display("FAIL wins_after got=%h exp=0028", runMask); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL wins_done got=%b exp=1", done); end
    tick();
  endtask

  task automatic test_empty();
    logic [1:0]  tps   [2];
    logic [15:0] masks [2];
    tps[0] = 2'd3; masks[0] = 16'hFFFF;
    tps[1] = 2'd0; masks[1] = 16'h0002;
    for (int k = 0; k < 2; k++) begin
      issue(tps[k], masks[k]);
      for (int c = 1; c <= 3; c++) begin
        total++; if ({cmdReady, msgValid, busy, done} !== ((c == 1) ? 4'b0010 : (c == 2) ? 4'b0011 : 4'b1000)) begin
          bad++; $display("FAIL empty%0d c=%0d got=%b", k, c, {cmdReady, msgValid, busy, done});
        end
        if (c < 3) tick();
      end
      total++; if (runMask !== 16'h0028) begin bad++; $display("FAIL empty%0d_run got=%h exp=0028", k, runMask); end
    end
  endtask

  task automatic test_reset_mid();
    msgReady = 1'b1;
    issue(2'd1, 16'h0048);
    for (int c = 1; c < 14; c++) begin
      if (c == 12) begin total++; if ({msgValid, msgDest, msgType} !== 9'h161) begin bad++; $display("FAIL rst_msg got=%h exp=161", {msgValid, msgDest, msgType}); end end
      tick();
    end
    total++; if ({busy, errMask} !== {1'b1, 16'h0008}) begin bad++; $display("FAIL rst_pre got=%h exp=10008", {busy, errMask}); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if ({cmdReady, msgValid, busy, done} !== 4'b1000) begin bad++; $display("FAIL rst_ctl got=%b exp=1000", {cmdReady, msgValid, busy, done}); end
    total++; if ({runMask, errMask} !== 32'h0) begin bad++; $display("FAIL rst_masks got=%h exp=0", {runMask, errMask}); end
    issue(2'd0, 16'h0003);
    for (int c = 1; c <= 5; c++) begin
      total++; if ({msgValid, done} !== {(c == 2), (c == 4)}) begin bad++; $display("FAIL rst_new c=%0d got=%b", c, {msgValid, done}); end
      if (c < 5) tick();
    end
    total++; if (runMask !== 16'h0001) begin bad++; $display("FAIL rst_new_run got=%h exp=0001", runMask); end
  endtask

  task automatic test_random();
    logic [15:0] mRun;
    logic [1:0]  tp;
    logic [15:0] mask;
    logic [3:0]  dq[$];
    int idx, c;
    logic doneSeen;
    do_reset();
    mRun = 16'h0;
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 2))
        0:       tp = 2'd0;
        1:       tp = 2'd2;
        default: tp = 2'd3;
      endcase
      mask = 16'($urandom);
      dq.delete();
      if (tp != 2'd3) for (int i = 0; i < NC; i++) if (mask[i] && i != SELF) dq.push_back(4'(i));
      idx = 0; c = 0; doneSeen = 1'b0;
      cmdType = tp; cmdMask = mask;
      while (!doneSeen && c < 300) begin
        if (c == 0) begin total++; if (cmdReady !== 1'b1) begin bad++; $display("FAIL rnd_rdy it=%0d got=%b", it, cmdReady); end end
        total++; if (runMask !== mRun) begin bad++; $display("FAIL rnd_run it=%0d c=%0d got=%h exp=%h", it, c, runMask, mRun); end
        if (msgValid === 1'b1) begin
          total++;
          if (idx >= dq.size()) begin bad++; $display("FAIL rnd_extra it=%0d got=%h", it, msgDest); end
          else if ({msgDest, msgType} !== {dq[idx], 2'b00, tp}) begin bad++; $display("FAIL rnd_msg it=%0d got=%h exp=%h", it, {msgDest, msgType}, {dq[idx], 2'b00, tp}); end
        end
        if (done === 1'b1) begin
          doneSeen = 1'b1;
          total++; if (idx != dq.size()) begin bad++; $display("FAIL rnd_count it=%0d got=%0d exp=%0d", it, idx, dq.size()); end
        end
        cmdValid = (c == 0);
        msgReady = 1'($urandom_range(0, 1));
        statusValid = ($urandom_range(0, 3) == 0);
        statusSrc = 4'($urandom_range(0, 15));
        statusRunning = 1'($urandom_range(0, 1));
        if (statusValid) mRun[statusSrc] = statusRunning;
        if (msgValid === 1'b1 && msgReady && idx < dq.size()) begin
          mRun[dq[idx]] = (tp == 2'd0);
          idx++;
        end
        tick();
        c++;
      end
      if (!doneSeen) begin bad++; total++; $display("FAIL rnd_timeout it=%0d got=nodone exp=done", it); end
    end
    cmdValid = 1'b0; statusValid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_basic();
    test_stop_report();
    test_timeout();
    test_kill_stall();
    test_fsm_wins();
    test_empty();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
